// File: rtl/uart_rx.sv
// UART receiver: 8N1-style framing with mid-bit sampling,
// single-entry valid/ready output, framing-error and overrun pulses.
module uart_rx #(
    parameter int DATA_WIDTH = 8,
    parameter int BAUD_RATE  = 115200,
    parameter int CLK_FREQ   = 100_000_000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  uart_in,
    output logic [DATA_WIDTH-1:0] data,
    output logic                  valid,
    input  logic                  ready,
    output logic                  frame_err,
    output logic                  overrun
);

    localparam int PULSE_WIDTH      = CLK_FREQ / BAUD_RATE;
    localparam int HALF_PULSE_WIDTH = PULSE_WIDTH / 2;
    localparam int CW = $clog2(PULSE_WIDTH + 1);
    localparam int IW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK
    } state_t;

    state_t                state, state_n;
    logic [CW-1:0]         clk_cnt, cnt_n;
    logic [IW-1:0]         bit_idx, idx_n;
    logic [DATA_WIDTH-1:0] shift, shift_n;
    logic [DATA_WIDTH-1:0] data_n;
    logic                  valid_n, ferr_n, ovr_n;
    logic [1:0]            sync;
    logic                  rx_s;

    assign rx_s = sync[1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync      <= 2'b11;
            state     <= IDLE;
            clk_cnt   <= '0;
            bit_idx   <= '0;
            shift     <= '0;
            data      <= '0;
            valid     <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            sync      <= {sync[0], uart_in};
            state     <= state_n;
            clk_cnt   <= cnt_n;
            bit_idx   <= idx_n;
            shift     <= shift_n;
            data      <= data_n;
            valid     <= valid_n;
            frame_err <= ferr_n;
            overrun   <= ovr_n;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = clk_cnt;
        idx_n   = bit_idx;
        shift_n = shift;
        data_n  = data;
        valid_n = valid && !ready;
        ferr_n  = 1'b0;
        ovr_n   = 1'b0;
        case (state)
            IDLE: begin
                if (!rx_s) begin
                    state_n = START;
                    cnt_n   = CW'(HALF_PULSE_WIDTH - 1);
                end
            end
            START: begin
                if (clk_cnt != '0) begin
                    cnt_n = clk_cnt - CW'(1);
                end else if (rx_s) begin
                    state_n = IDLE;
                end else begin
                    state_n = DATA;
                    idx_n   = '0;
                    cnt_n   = CW'(PULSE_WIDTH - 1);
                end
            end
            DATA: begin
                if (clk_cnt != '0) begin
                    cnt_n = clk_cnt - CW'(1);
                end else begin
                    shift_n[bit_idx] = rx_s;
                    cnt_n = CW'(PULSE_WIDTH - 1);
                    if (bit_idx == IW'(DATA_WIDTH - 1))
                        state_n = STOP;
                    else
                        idx_n = bit_idx + IW'(1);
                end
            end
            STOP: begin
                if (clk_cnt != '0) begin
                    cnt_n = clk_cnt - CW'(1);
                end else if (rx_s) begin
                    // Back to IDLE at mid-stop so a back-to-back start is seen
                    state_n = IDLE;
                    if (!valid || ready) begin
                        data_n  = shift;
                        valid_n = 1'b1;
                    end else begin
                        ovr_n = 1'b1;
                    end
                end else begin
                    ferr_n  = 1'b1;
                    state_n = BREAK;
                end
            end
            BREAK: begin
                if (rx_s)
                    state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: frame-level model with expected-word queue,
// per-cycle output compare and directed scenarios.
module tb_uart_rx;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       uart_in = 1'b1;
    logic [7:0] data;
    logic       valid;
    logic       ready = 1'b1;
    logic       frame_err;
    logic       overrun;

    int total = 0;
    int bad = 0;
    int ferr_seen = 0;
    int ovr_seen = 0;
    int exp_ferr = 0;
    int exp_ovr = 0;
    int rx_cnt = 0;
    logic [7:0] q[$];

    uart_rx #(
        .DATA_WIDTH(8),
        .BAUD_RATE(100_000),
        .CLK_FREQ(1_000_000)
    ) dut (
        .clk(clk),
        .rst(rst),
        .uart_in(uart_in),
        .data(data),
        .valid(valid),
        .ready(ready),
        .frame_err(frame_err),
        .overrun(overrun)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d (0x%0h) want %0d (0x%0h)",
                     name, act, act, exp, exp);
        end
    endtask

    // Outputs sampled on negedge; a transfer happens at the next posedge
    always @(negedge clk) begin
        if (!rst) begin
            if (frame_err) ferr_seen++;
            if (overrun) ovr_seen++;
            if (valid) begin
                total++;
                if (q.size() == 0) begin
                    bad++;
                    $display("FAIL spurious_word: got data=0x%0h want no valid", data);
                end else if (data !== q[0]) begin
                    bad++;
                    $display("FAIL word: got 0x%0h want 0x%0h", data, q[0]);
                end
                if (ready && q.size() != 0) begin
                    void'(q.pop_front());
                    rx_cnt++;
                end
            end
        end
    end

    task automatic drive(input logic v, input int n);
        uart_in = v;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b, input logic stop_ok, input int stop_len);
        drive(1'b0, 10);
        for (int i = 0; i < 8; i++) drive(b[i], 10);
        if (stop_ok) begin
            if (ready || q.size() == 0) q.push_back(b);
            else exp_ovr++;
        end else begin
            exp_ferr++;
        end
        drive(stop_ok, stop_len);
    endtask

    initial begin
        int lat;
        int base;
        logic [7:0] first;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check("reset_valid", valid, 0);
        check("reset_data", data, 0);
        check("reset_ferr", frame_err, 0);
        check("reset_ovr", overrun, 0);
        drive(1'b1, 5);

        // 1: single frame, latency and literal data
        lat = -1;
        first = 8'h00;
        fork
            send(8'hA5, 1'b1, 10);
            begin
                for (int c = 1; c <= 200; c++) begin
                    @(posedge clk);
                    #1;
                    if (valid && lat < 0) begin
                        lat = c;
                        first = data;
                    end
                end
            end
        join_any
        drive(1'b1, 120);
        check("t1_latency_ok", (lat >= 96 && lat <= 98) ? 1 : 0, 1);
        check("t1_data", first, 8'hA5);
        check("t1_rx_cnt", rx_cnt, 1);

        // 2: back-to-back frames
        base = rx_cnt;
        send(8'h00, 1'b1, 10);
        send(8'hFF, 1'b1, 10);
        send(8'h55, 1'b1, 10);
        send(8'h80, 1'b1, 10);
        drive(1'b1, 20);
        check("t2_rx_cnt", rx_cnt - base, 4);
        check("t2_queue_empty", q.size(), 0);

        // 3: short glitch then a real frame
        drive(1'b0, 3);
        drive(1'b1, 30);
        check("t3_no_valid", valid, 0);
        check("t3_no_ferr", ferr_seen, 0);
        base = rx_cnt;
        send(8'h3C, 1'b1, 20);
        check("t3_rx_cnt", rx_cnt - base, 1);

        // 4: stop bit low, held low
        send(8'h12, 1'b0, 50);
        check("t4_ferr_once", ferr_seen, 1);
        check("t4_no_valid", valid, 0);
        drive(1'b1, 20);
        base = rx_cnt;
        send(8'h34, 1'b1, 20);
        check("t4_rx_cnt", rx_cnt - base, 1);

        // 5: overrun while output is full
        ready = 1'b0;
        send(8'h11, 1'b1, 10);
        send(8'h22, 1'b1, 20);
        check("t5_valid_held", valid, 1);
        check("t5_data_held", data, 8'h11);
        check("t5_ovr_once", ovr_seen, 1);
        base = rx_cnt;
        ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("t5_valid_drop", valid, 0);
        check("t5_accepted", rx_cnt - base, 1);
        drive(1'b1, 20);
        check("t5_no_22", rx_cnt - base, 1);

        // 6: reset in the middle of data bit 4
        drive(1'b0, 10);
        drive(1'b1, 10);
        drive(1'b0, 10);
        drive(1'b0, 10);
        drive(1'b1, 10);
        drive(1'b1, 5);
        rst = 1'b1;
        #1;
        check("t6_valid_rst", valid, 0);
        uart_in = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        drive(1'b1, 30);
        check("t6_no_partial", valid, 0);
        base = rx_cnt;
        send(8'h66, 1'b1, 20);
        check("t6_rx_cnt", rx_cnt - base, 1);

        check("final_ferr", ferr_seen, exp_ferr);
        check("final_ovr", ovr_seen, exp_ovr);
        check("final_queue", q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
